// File: rtl/phase_sequencer.sv
// phase_sequencer: major-cycle timing generator feeding the instruction decoders.
// Produces one-hot step clocks (ck) and end-of-step strobes (stb); restarts at
// step 0 when the active decoder raises done, and flags a sticky overrun when
// the last step completes without done.
// Optional feature macro: SEQ_SINGLESTEP_EN adds singlestep/step_req inputs.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no instruction in progress, ck/stb/step/running low
// CK    | step clock phase: ck[step] high for CK_CYCLES cycles
// STB   | strobe phase: ck[step] and stb[step] high for STB_CYCLES cycles

module phase_sequencer #(
  parameter int NSTEPS     = 6,
  parameter int CK_CYCLES  = 2,
  parameter int STB_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       done,
`ifdef SEQ_SINGLESTEP_EN
  input  logic       singlestep,
  input  logic       step_req,
`endif
  output logic [5:0] ck,
  output logic [5:0] stb,
  output logic [2:0] step,
  output logic       running,
  output logic       overrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CK   = 2'd1,
    S_STB  = 2'd2
  } state_t;

  localparam int SUB_MAX = (CK_CYCLES > STB_CYCLES) ? CK_CYCLES : STB_CYCLES;
  localparam int SW      = $clog2(SUB_MAX + 1);

  localparam logic [SW-1:0] CK_LAST   = SW'(CK_CYCLES - 1);
  localparam logic [SW-1:0] STB_LAST  = SW'(STB_CYCLES - 1);
  localparam logic [2:0]    STEP_LAST = 3'(NSTEPS - 1);

  state_t        state;
  logic [SW-1:0] sub;
  logic          start_req;
  logic          chain_req;

  // Select what may launch an instruction from IDLE and what may chain after done.
  // In single-step mode only an explicit request launches, and nothing chains.
`ifdef SEQ_SINGLESTEP_EN
  assign start_req = singlestep ? step_req : run;
  assign chain_req = singlestep ? 1'b0     : run;
`else
  assign start_req = run;
  assign chain_req = run;
`endif

  // Sequencer FSM; every output is registered alongside the state so that
  // done/run never reach an output combinationally.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      sub     <= '0;
      step    <= '0;
      ck      <= '0;
      stb     <= '0;
      running <= 1'b0;
      overrun <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_req && !overrun) begin
            state   <= S_CK;
            sub     <= '0;
            step    <= '0;
            ck      <= 6'b000001;
            stb     <= '0;
            running <= 1'b1;
          end
        end

        S_CK, S_STB: begin
          if (done) begin
            // done outranks sub-phase/step advance and the overrun check
            if (chain_req) begin
              state   <= S_CK;
              sub     <= '0;
              step    <= '0;
              ck      <= 6'b000001;
              stb     <= '0;
              running <= 1'b1;
            end else begin
              state   <= S_IDLE;
              sub     <= '0;
              step    <= '0;
              ck      <= '0;
              stb     <= '0;
              running <= 1'b0;
            end
          end else if (state == S_CK) begin
            if (sub == CK_LAST) begin
              state <= S_STB;
              sub   <= '0;
              stb   <= ck;
            end else begin
              sub <= sub + SW'(1);
            end
          end else begin
            if (sub == STB_LAST) begin
              if (step == STEP_LAST) begin
                state   <= S_IDLE;
                sub     <= '0;
                step    <= '0;
                ck      <= '0;
                stb     <= '0;
                running <= 1'b0;
                overrun <= 1'b1;
              end else begin
                state <= S_CK;
                sub   <= '0;
                step  <= step + 3'd1;
                ck    <= 6'b000001 << (step + 3'd1);
                stb   <= '0;
              end
            end else begin
              sub <= sub + SW'(1);
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          sub     <= '0;
          step    <= '0;
          ck      <= '0;
          stb     <= '0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench for phase_sequencer. A cycle-time reference model predicts
// the outputs of each next cycle; a separate monitor compares them with the DUT.
module tb_phase_sequencer;

  localparam int NSTEPS = 6;
  localparam int CKC    = 2;
  localparam int STBC   = 1;
  localparam int PER    = CKC + STBC;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       done = 1'b0;
  logic [5:0] ck;
  logic [5:0] stb;
  logic [2:0] step;
  logic       running;
  logic       overrun;
`ifdef SEQ_SINGLESTEP_EN
  logic       singlestep = 1'b0;
  logic       step_req = 1'b0;
`endif

  always #5 clk = ~clk;

  phase_sequencer #(.NSTEPS(NSTEPS), .CK_CYCLES(CKC), .STB_CYCLES(STBC)) dut (
    .clk(clk),
    .reset(reset),
    .run(run),
    .done(done),
`ifdef SEQ_SINGLESTEP_EN
    .singlestep(singlestep),
    .step_req(step_req),
`endif
    .ck(ck),
    .stb(stb),
    .step(step),
    .running(running),
    .overrun(overrun)
  );

  int checks = 0;
  int passed = 0;
  logic [16:0] exp_q[$];

  // Reference model: instruction position measured in cycles since start.
  bit m_busy = 1'b0;
  bit m_ovr  = 1'b0;
  int m_t    = 0;
  bit m_ss   = 1'b0;
  bit m_sreq = 1'b0;
  int mode   = 0;

  function automatic logic [16:0] model_out();
    logic [5:0] ckv;
    logic [5:0] stbv;
    int s;
    int ph;
    if (!m_busy) return {6'b0, 6'b0, 3'b0, 1'b0, m_ovr};
    s    = m_t / PER;
    ph   = m_t % PER;
    ckv  = 6'(1 << s);
    stbv = (ph >= CKC) ? ckv : 6'b0;
    return {ckv, stbv, 3'(s), 1'b1, m_ovr};
  endfunction

  // Decoder stand-in: done derived from the predicted ck/stb of this cycle.
  function automatic bit decode(input int md, input logic [16:0] o);
    logic [5:0] c;
    logic [5:0] s;
    c = o[16:11];
    s = o[10:5];
    if (md >= 1 && md <= 6)  return c[md-1];
    if (md >= 7 && md <= 12) return s[md-7];
    if (md == 13)            return ($urandom_range(0, 5) == 0);
    return 1'b0;
  endfunction

  task automatic cycle(input bit rst, input bit r);
    logic [16:0] cur;
    bit dn;
    bit start;
    bit chain;
    @(negedge clk);
    cur = model_out();
    dn  = decode(mode, cur);
`ifdef SEQ_SINGLESTEP_EN
    m_sreq     = ($urandom_range(0, 7) == 0);
    singlestep = m_ss;
    step_req   = m_sreq;
`endif
    reset = rst;
    run   = r;
    done  = dn;
    start = m_ss ? m_sreq : r;
    chain = m_ss ? 1'b0 : r;
    if (rst) begin
      m_busy = 1'b0; m_t = 0; m_ovr = 1'b0;
    end else if (!m_busy) begin
      if (start && !m_ovr) begin m_busy = 1'b1; m_t = 0; end
    end else if (dn) begin
      if (chain) m_t = 0;
      else m_busy = 1'b0;
    end else begin
      m_t++;
      if (m_t == NSTEPS * PER) begin m_busy = 1'b0; m_ovr = 1'b1; end
    end
    exp_q.push_back(model_out());
  endtask

  // Monitor: compare each predicted cycle just after the edge that produces it.
  initial begin
    logic [16:0] e;
    logic [16:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {ck, stb, step, running, overrun};
        checks++;
        if (a === e) passed++;
        else $display("FAIL outputs t=%0t: got ck=%b stb=%b step=%0d running=%b overrun=%b, want ck=%b stb=%b step=%0d running=%b overrun=%b",
                      $time, a[16:11], a[10:5], a[4:2], a[1], a[0], e[16:11], e[10:5], e[4:2], e[1], e[0]);
      end
    end
  end

  initial begin
    // free-running, never done: overrun at cycle 19, blocked until reset
    mode = 0; m_ss = 1'b0;
    cycle(1, 0);
    for (int i = 0; i < 26; i++) cycle(0, 1);
    cycle(1, 1);
    // done on ck[1]: 4-cycle repeating pattern
    mode = 2;
    for (int i = 0; i < 17; i++) cycle(0, 1);
    for (int i = 0; i < 6; i++) cycle(0, 0);
    // run dropped in cycle 2, done on ck[2]: idle at cycle 8
    mode = 3;
    cycle(1, 0);
    for (int i = 0; i < 12; i++) cycle(0, (i < 2));
    // reset while ck[2] is high
    mode = 0;
    cycle(1, 0);
    for (int i = 0; i < 8; i++) cycle(0, 1);
    cycle(1, 1);
    for (int i = 0; i < 4; i++) cycle(0, 0);
    // done on the very last strobe beats overrun
    mode = 12;
    for (int i = 0; i < 40; i++) cycle(0, 1);
    // randomized segments
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      int runp;
      mode = $urandom_range(0, 13);
      len  = $urandom_range(5, 40);
      runp = $urandom_range(0, 3);
`ifdef SEQ_SINGLESTEP_EN
      m_ss = ($urandom_range(0, 2) == 0);
`endif
      if ($urandom_range(0, 2) == 0) cycle(1, 0);
      for (int i = 0; i < len; i++)
        cycle(($urandom_range(0, 60) == 0), ($urandom_range(0, 3) >= runp));
    end
    m_ss = 1'b0;
    mode = 0;
    for (int i = 0; i < 3; i++) cycle(0, 0);
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
